// File: rtl/ro_puf_compare.sv
// ============================================================================
// Module   : ro_puf_compare
// Summary  : Enables and clears a ring-oscillator pair, then counts rising
//            edges of both outputs over a fixed clk window. It compares the
//            two counts to form one PUF response bit. The optional macro
//            RO_PUF_TIE_FLAG_EN adds a registered "tie" output that flags
//            equal counts.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ro_puf_compare #(
  parameter int CNT_W      = 16,
  parameter int WINDOW     = 64,
  parameter int CLR_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ro_a,
  input  logic             ro_b,
  output logic             ro_enable,
  output logic             ro_reset,
  output logic             busy,
  output logic             done,
  output logic             response,
`ifdef RO_PUF_TIE_FLAG_EN
  output logic             tie,
`endif
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b
);

  localparam int c_SETTLE  = 3;
  localparam int c_TMR_MAX = (WINDOW > CLR_CYCLES)
                           ? ((WINDOW > c_SETTLE) ? WINDOW : c_SETTLE)
                           : ((CLR_CYCLES > c_SETTLE) ? CLR_CYCLES : c_SETTLE);
  localparam int c_TMR_W   = $clog2(c_TMR_MAX);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_SETTLE = 3'd2,
    S_COUNT  = 3'd3,
    S_CMP    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [c_TMR_W-1:0] tmr_q, tmr_d;
  logic [2:0]         sync_a_q, sync_b_q;
  logic [CNT_W-1:0]   cnt_a_q, cnt_b_q;
  logic               resp_q;
  logic               w_edge_a, w_edge_b, w_clr_entry;

  // sync_x_q[1] is the synchronized level; sync_x_q[2] is its previous value
  assign w_edge_a    = sync_a_q[1] & ~sync_a_q[2];
  assign w_edge_b    = sync_b_q[1] & ~sync_b_q[2];
  assign w_clr_entry = (state_d == S_CLEAR) && (state_q != S_CLEAR);

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    ro_enable = 1'b0;
    ro_reset  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = S_CLEAR;
          tmr_d   = c_TMR_W'(CLR_CYCLES - 1);
        end
      end
      S_CLEAR: begin
        ro_enable = 1'b1;
        ro_reset  = 1'b1;
        if (tmr_q == '0) begin
          state_d = S_SETTLE;
          tmr_d   = c_TMR_W'(c_SETTLE - 1);
        end else begin
          tmr_d = tmr_q - c_TMR_W'(1);
        end
      end
      S_SETTLE: begin
        ro_enable = 1'b1;
        if (tmr_q == '0) begin
          state_d = S_COUNT;
          tmr_d   = c_TMR_W'(WINDOW - 1);
        end else begin
          tmr_d = tmr_q - c_TMR_W'(1);
        end
      end
      S_COUNT: begin
        ro_enable = 1'b1;
        if (tmr_q == '0) begin
          state_d = S_CMP;
        end else begin
          tmr_d = tmr_q - c_TMR_W'(1);
        end
      end
      S_CMP: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) begin
          state_d = S_CLEAR;
          tmr_d   = c_TMR_W'(CLR_CYCLES - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      tmr_q    <= '0;
      sync_a_q <= '0;
      sync_b_q <= '0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      sync_a_q <= {sync_a_q[1:0], ro_a};
      sync_b_q <= {sync_b_q[1:0], ro_b};
    end
  end

  // Counters saturate at all-ones so a fast oscillator can never wrap low
  always_ff @(posedge clk) begin
    if (reset || w_clr_entry) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      resp_q  <= 1'b0;
    end else begin
      if (state_q == S_COUNT && w_edge_a && cnt_a_q != {CNT_W{1'b1}}) begin
        cnt_a_q <= cnt_a_q + CNT_W'(1);
      end
      if (state_q == S_COUNT && w_edge_b && cnt_b_q != {CNT_W{1'b1}}) begin
        cnt_b_q <= cnt_b_q + CNT_W'(1);
      end
      if (state_q == S_CMP) begin
        resp_q <= (cnt_a_q > cnt_b_q);
      end
    end
  end

`ifdef RO_PUF_TIE_FLAG_EN
  logic tie_q;
  always_ff @(posedge clk) begin
    if (reset || w_clr_entry) begin
      tie_q <= 1'b0;
    end else if (state_q == S_CMP) begin
      tie_q <= (cnt_a_q == cnt_b_q);
    end
  end
  assign tie = tie_q;
`endif

  assign count_a  = cnt_a_q;
  assign count_b  = cnt_b_q;
  assign response = resp_q;

endmodule

`default_nettype wire
